// File: rtl/pool_pkg.sv
// Shared definitions for the streaming pooling layer.
//   clog2      : ceiling log2 used to size addresses and accumulators
//   MODE_*     : reduction mode selectors for the MODE parameter
//   rd_state_t : window read/reduce FSM states
package pool_pkg;

  localparam int MODE_MAX = 0;
  localparam int MODE_AVG = 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACC,
    ST_DRAIN,
    ST_HOLD
  } rd_state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/pool_line_ram.sv
// Simple dual-port line buffer RAM with a synchronous (1-cycle) read port.
// Ports:
//   clk              : clock
//   wr_en/addr/data  : write port, written on the rising edge
//   rd_en/rd_addr    : read request; rd_data is valid the following cycle
//   rd_data          : registered read data, holds its value when rd_en=0
module pool_line_ram #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [1 << ADDR_W];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/pool_layer_v2.sv
// Streaming 2-D pooling layer (max or average, optional ReLU) for the serial
// CNN datapath. Elements arrive and leave in row, column, channel order with
// the channel index fastest.
// Ports:
//   clk, rst       : clock, asynchronous active-low reset
//   blob_din*      : input element stream (valid/ready, eop informational)
//   blob_dout*     : pooled output stream (valid/ready, eop on last element)
module pool_layer_v2
  import pool_pkg::*;
#(
  parameter int DIN_W     = 16,
  parameter int W_IN      = 32,
  parameter int H_IN      = 32,
  parameter int C         = 32,
  parameter int POOL_K    = 3,
  parameter int STRIDE    = 2,
  parameter int MODE      = 0,
  parameter int AVG_SHIFT = 3,
  parameter int RELU      = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIN_W-1:0] blob_din,
  input  logic             blob_din_en,
  output logic             blob_din_rdy,
  input  logic             blob_din_eop,
  output logic [DIN_W-1:0] blob_dout,
  output logic             blob_dout_en,
  input  logic             blob_dout_rdy,
  output logic             blob_dout_eop
);

  localparam int W_OUT     = (W_IN - POOL_K) / STRIDE + 1;
  localparam int H_OUT     = (H_IN - POOL_K) / STRIDE + 1;
  localparam int RING      = POOL_K + STRIDE;
  localparam int ROW_WORDS = W_IN * C;
  localparam int ADDR_W    = clog2(RING * ROW_WORDS);
  localparam int SUM_W     = DIN_W + clog2(POOL_K * POOL_K);
  localparam int CNT_W     = clog2(H_IN + W_IN + C + 2 * RING) + 1;

  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t ONE       = cnt_t'(1);
  localparam cnt_t C_LAST    = cnt_t'(C - 1);
  localparam cnt_t W_LAST    = cnt_t'(W_IN - 1);
  localparam cnt_t H_LAST    = cnt_t'(H_IN - 1);
  localparam cnt_t WO_LAST   = cnt_t'(W_OUT - 1);
  localparam cnt_t HO_LAST   = cnt_t'(H_OUT - 1);
  localparam cnt_t K_LAST    = cnt_t'(POOL_K - 1);
  localparam cnt_t K_C       = cnt_t'(POOL_K);
  localparam cnt_t S_C       = cnt_t'(STRIDE);
  localparam cnt_t RING_C    = cnt_t'(RING);
  localparam cnt_t RING_LAST = cnt_t'(RING - 1);

  localparam logic [ADDR_W-1:0] ROW_WORDS_A = ADDR_W'(ROW_WORDS);
  localparam logic [ADDR_W-1:0] C_A         = ADDR_W'(C);

  // Write side
  cnt_t wr_ch, wr_col, wr_row, wr_slot;
  logic wr_done, armed, wr_fire;
  logic [ADDR_W-1:0] wr_addr;

  // Read side
  rd_state_t state, state_nxt;
  cnt_t out_ch, out_col, out_row, base_row, base_slot, col_base, kx, ky;
  cnt_t nxt_ch, nxt_col, nxt_row, nxt_base, nxt_slot, nxt_colb;
  cnt_t rd_slot_sum, rd_slot;
  logic [ADDR_W-1:0] rd_addr;
  logic rd_vld, rd_first, out_last, rows_ready, nxt_ready, out_xfer;

  // Reduce path
  logic signed [DIN_W-1:0] ram_q;
  logic signed [SUM_W-1:0] ram_ext, acc, fold_val;
  logic [DIN_W-1:0] res_pre, result, dout_q;
  logic eop_q;

  // Frame end is fixed by position, so the input eop flag carries no information.
  logic din_eop_unused;
  assign din_eop_unused = blob_din_eop;

  assign wr_fire  = blob_din_en && blob_din_rdy;
  assign out_last = (out_ch == C_LAST) && (out_col == WO_LAST) && (out_row == HO_LAST);
  assign out_xfer = (state == ST_HOLD) && blob_dout_rdy;
  assign wr_addr  = ADDR_W'(wr_slot) * ROW_WORDS_A + ADDR_W'(wr_col) * C_A + ADDR_W'(wr_ch);

  // The last output row also waits for the whole frame, including trailing
  // rows no window uses, so clearing all counters after it is always safe.
  assign rows_ready = wr_done || ((out_row != HO_LAST) && (wr_row >= base_row + K_C));

  pool_line_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DIN_W)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_fire),
    .wr_addr (wr_addr),
    .wr_data (blob_din),
    .rd_en   (state == ST_ACC),
    .rd_addr (rd_addr),
    .rd_data (ram_q)
  );

  // Releases the input side one clock after reset deasserts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) armed <= 1'b0;
    else      armed <= 1'b1;
  end

  // Write counters; wr_slot tracks wr_row mod RING incrementally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ch   <= '0;
      wr_col  <= '0;
      wr_row  <= '0;
      wr_slot <= '0;
      wr_done <= 1'b0;
    end else if (out_xfer && out_last) begin
      wr_ch   <= '0;
      wr_col  <= '0;
      wr_row  <= '0;
      wr_slot <= '0;
      wr_done <= 1'b0;
    end else if (wr_fire) begin
      if (wr_ch != C_LAST) begin
        wr_ch <= wr_ch + ONE;
      end else begin
        wr_ch <= '0;
        if (wr_col != W_LAST) begin
          wr_col <= wr_col + ONE;
        end else begin
          wr_col <= '0;
          if (wr_row != H_LAST) begin
            wr_row  <= wr_row + ONE;
            wr_slot <= (wr_slot == RING_LAST) ? '0 : wr_slot + ONE;
          end else begin
            wr_row  <= '0;
            wr_slot <= '0;
            wr_done <= 1'b1;
          end
        end
      end
    end
  end

  // Position of the output after the current one, and whether its rows are in.
  always_comb begin
    nxt_ch   = out_ch;
    nxt_col  = out_col;
    nxt_row  = out_row;
    nxt_base = base_row;
    nxt_slot = base_slot;
    nxt_colb = col_base;
    if (out_ch != C_LAST) begin
      nxt_ch = out_ch + ONE;
    end else begin
      nxt_ch = '0;
      if (out_col != WO_LAST) begin
        nxt_col  = out_col + ONE;
        nxt_colb = col_base + S_C;
      end else begin
        nxt_col  = '0;
        nxt_colb = '0;
        nxt_row  = out_row + ONE;
        nxt_base = base_row + S_C;
        nxt_slot = (base_slot + S_C >= RING_C) ? base_slot + S_C - RING_C : base_slot + S_C;
      end
    end
    nxt_ready = wr_done || ((nxt_row != HO_LAST) && (wr_row >= nxt_base + K_C));
  end

  // Ring row of the current kernel row; base_slot + ky is always below 2*RING.
  always_comb begin
    rd_slot_sum = base_slot + ky;
    rd_slot     = (rd_slot_sum >= RING_C) ? rd_slot_sum - RING_C : rd_slot_sum;
    rd_addr     = ADDR_W'(rd_slot) * ROW_WORDS_A + ADDR_W'(col_base + kx) * C_A
                + ADDR_W'(out_ch);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (rows_ready) state_nxt = ST_ACC;
      ST_ACC:   if ((kx == K_LAST) && (ky == K_LAST)) state_nxt = ST_DRAIN;
      ST_DRAIN: state_nxt = ST_HOLD;
      ST_HOLD: begin
        if (blob_dout_rdy) begin
          if (out_last)       state_nxt = ST_IDLE;
          else if (nxt_ready) state_nxt = ST_ACC;
          else                state_nxt = ST_IDLE;
        end
      end
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    blob_din_rdy  = armed && !wr_done && (wr_row < base_row + RING_C);
    blob_dout_en  = (state == ST_HOLD);
    blob_dout     = dout_q;
    blob_dout_eop = eop_q;
  end

  // Kernel walk (kx fastest) and output position counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      kx        <= '0;
      ky        <= '0;
      rd_vld    <= 1'b0;
      rd_first  <= 1'b0;
      out_ch    <= '0;
      out_col   <= '0;
      out_row   <= '0;
      base_row  <= '0;
      base_slot <= '0;
      col_base  <= '0;
    end else begin
      rd_vld   <= (state == ST_ACC);
      rd_first <= (state == ST_ACC) && (kx == '0) && (ky == '0);
      if (state == ST_ACC) begin
        if (kx == K_LAST) begin
          kx <= '0;
          ky <= (ky == K_LAST) ? '0 : ky + ONE;
        end else begin
          kx <= kx + ONE;
        end
      end
      if (out_xfer) begin
        if (out_last) begin
          out_ch    <= '0;
          out_col   <= '0;
          out_row   <= '0;
          base_row  <= '0;
          base_slot <= '0;
          col_base  <= '0;
        end else begin
          out_ch    <= nxt_ch;
          out_col   <= nxt_col;
          out_row   <= nxt_row;
          base_row  <= nxt_base;
          base_slot <= nxt_slot;
          col_base  <= nxt_colb;
        end
      end
    end
  end

  // Fold of the returning RAM word into the running max/sum; the first word
  // of a window seeds the accumulator.
  always_comb begin
    ram_ext = SUM_W'(ram_q);
    if (rd_first)              fold_val = ram_ext;
    else if (MODE == MODE_AVG) fold_val = acc + ram_ext;
    else                       fold_val = (ram_ext > acc) ? ram_ext : acc;
    if (MODE == MODE_AVG) res_pre = DIN_W'(fold_val >>> AVG_SHIFT);
    else                  res_pre = fold_val[DIN_W-1:0];
    result = ((RELU != 0) && res_pre[DIN_W-1]) ? '0 : res_pre;
  end

  // DRAIN sees the last word of the window, so the result is final there.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc    <= '0;
      dout_q <= '0;
      eop_q  <= 1'b0;
    end else begin
      if (rd_vld) acc <= fold_val;
      if (state == ST_DRAIN) begin
        dout_q <= result;
        eop_q  <= out_last;
      end else if (out_xfer && out_last) begin
        eop_q  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pool_layer_v2.sv
// Directed bench for pool_layer_v2: several parameter sets instantiated side
// by side, each exercised by its own scenario task.
module tb_pool_layer_v2;

  localparam int N     = 6;
  localparam int DW    = 16;
  localparam int LIMIT = 20000;

  // 0: 4x4 max   1: 4x4 avg   2: 5x5 K3 max   3/4: 2x2x2 relu on/off
  // 5: 9 wide x 10 high x 3 ch, K3 S2 max, signed random data
  localparam int CFG_W[N] = '{4, 4, 5, 2, 2, 9};
  localparam int CFG_H[N] = '{4, 4, 5, 2, 2, 10};
  localparam int CFG_C[N] = '{1, 1, 1, 2, 2, 3};
  localparam int CFG_K[N] = '{2, 2, 3, 2, 2, 3};
  localparam int CFG_S[N] = '{2, 2, 2, 2, 2, 2};
  localparam int CFG_M[N] = '{0, 1, 0, 0, 0, 0};
  localparam int CFG_A[N] = '{3, 2, 3, 3, 3, 3};
  localparam int CFG_R[N] = '{1, 1, 1, 1, 0, 0};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [DW-1:0] din      [N];
  logic          din_en   [N];
  logic          din_rdy  [N];
  logic          din_eop  [N];
  logic [DW-1:0] dout     [N];
  logic          dout_en  [N];
  logic          dout_rdy [N];
  logic          dout_eop [N];

  int n_checks = 0;
  int n_errors = 0;

  logic [DW-1:0] stim_q[$];
  logic [DW-1:0] exp_q[$];

  for (genvar g = 0; g < N; g++) begin : g_dut
    pool_layer_v2 #(
      .DIN_W     (DW),
      .W_IN      (CFG_W[g]),
      .H_IN      (CFG_H[g]),
      .C         (CFG_C[g]),
      .POOL_K    (CFG_K[g]),
      .STRIDE    (CFG_S[g]),
      .MODE      (CFG_M[g]),
      .AVG_SHIFT (CFG_A[g]),
      .RELU      (CFG_R[g])
    ) u_dut (
      .clk           (clk),
      .rst           (rst),
      .blob_din      (din[g]),
      .blob_din_en   (din_en[g]),
      .blob_din_rdy  (din_rdy[g]),
      .blob_din_eop  (din_eop[g]),
      .blob_dout     (dout[g]),
      .blob_dout_en  (dout_en[g]),
      .blob_dout_rdy (dout_rdy[g]),
      .blob_dout_eop (dout_eop[g])
    );
  end

  task automatic send_frame(input int idx, input int en_pct);
    int i;
    int guard;
    i = 0;
    guard = 0;
    while (i < stim_q.size() && guard < LIMIT) begin
      @(posedge clk); #1;
      din_en[idx]  = ($urandom_range(0, 99) < en_pct);
      din[idx]     = stim_q[i];
      din_eop[idx] = (i == stim_q.size() - 1);
      @(negedge clk);
      if (din_en[idx] && din_rdy[idx]) i++;
      guard++;
    end
    @(posedge clk); #1;
    din_en[idx]  = 1'b0;
    din_eop[idx] = 1'b0;
    n_checks++;
    if (i != stim_q.size()) begin
      n_errors++;
      $display("[TB] FAIL send_timeout dut%0d: accepted %0d, required %0d", idx, i, stim_q.size());
    end
  endtask

  task automatic recv_frame(input int idx, input int rdy_pct, input string name);
    int k;
    int guard;
    logic stalled;
    logic exp_eop;
    logic [DW-1:0] held;
    k = 0;
    guard = 0;
    stalled = 1'b0;
    held = '0;
    while (k < exp_q.size() && guard < LIMIT) begin
      @(posedge clk); #1;
      dout_rdy[idx] = ($urandom_range(0, 99) < rdy_pct);
      @(negedge clk);
      if (stalled) begin
        n_checks++;
        if (dout_en[idx] !== 1'b1 || dout[idx] !== held) begin
          n_errors++;
          $display("[TB] FAIL %s_stall_hold: got en=%b data=%h, required en=1 data=%h",
                   name, dout_en[idx], dout[idx], held);
        end
      end
      stalled = 1'b0;
      if (dout_en[idx] === 1'b1) begin
        if (dout_rdy[idx]) begin
          exp_eop = (k == exp_q.size() - 1);
          n_checks++;
          if (dout[idx] !== exp_q[k]) begin
            n_errors++;
            $display("[TB] FAIL %s_data[%0d]: got %h, required %h", name, k, dout[idx], exp_q[k]);
          end
          n_checks++;
          if (dout_eop[idx] !== exp_eop) begin
            n_errors++;
            $display("[TB] FAIL %s_eop[%0d]: got %b, required %b", name, k, dout_eop[idx], exp_eop);
          end
          k++;
        end else begin
          stalled = 1'b1;
          held = dout[idx];
        end
      end
      guard++;
    end
    @(posedge clk); #1;
    dout_rdy[idx] = 1'b0;
    n_checks++;
    if (k != exp_q.size()) begin
      n_errors++;
      $display("[TB] FAIL %s_timeout: got %0d outputs, required %0d", name, k, exp_q.size());
    end
  endtask

  task automatic run_frame(input int idx, input int en_pct, input int rdy_pct, input string name);
    fork
      send_frame(idx, en_pct);
      recv_frame(idx, rdy_pct, name);
    join
    @(negedge clk);
    n_checks++;
    if (dout_en[idx] !== 1'b0 || din_rdy[idx] !== 1'b1) begin
      n_errors++;
      $display("[TB] FAIL %s_idle_after: got en=%b rdy=%b, required en=0 rdy=1",
               name, dout_en[idx], din_rdy[idx]);
    end
  endtask

  task automatic load_ramp(input int n, input int first);
    stim_q.delete();
    for (int i = 0; i < n; i++) stim_q.push_back(DW'(first + i));
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      n_checks++;
      if (din_rdy[i] !== 1'b0 || dout_en[i] !== 1'b0 || dout_eop[i] !== 1'b0 || dout[i] !== '0) begin
        n_errors++;
        $display("[TB] FAIL reset_state dut%0d: got rdy=%b en=%b eop=%b dout=%h, required 0 0 0 0000",
                 i, din_rdy[i], dout_en[i], dout_eop[i], dout[i]);
      end
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (din_rdy[0] !== 1'b0) begin
      n_errors++;
      $display("[TB] FAIL reset_rdy_before_edge: got %b, required 0", din_rdy[0]);
    end
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      n_checks++;
      if (din_rdy[i] !== 1'b1) begin
        n_errors++;
        $display("[TB] FAIL reset_rdy_after_edge dut%0d: got %b, required 1", i, din_rdy[i]);
      end
    end
  endtask

  task automatic test_max_basic();
    load_ramp(16, 0);
    exp_q = '{16'd5, 16'd7, 16'd13, 16'd15};
    run_frame(0, 100, 100, "max4x4");
  endtask

  task automatic test_back_to_back();
    load_ramp(16, 100);
    exp_q = '{16'd105, 16'd107, 16'd113, 16'd115};
    run_frame(0, 70, 50, "b2b4x4");
  endtask

  task automatic test_avg();
    load_ramp(16, 0);
    exp_q = '{16'd2, 16'd4, 16'd10, 16'd12};
    run_frame(1, 100, 100, "avg4x4");
  endtask

  task automatic test_overlap();
    load_ramp(25, 0);
    exp_q = '{16'd12, 16'd14, 16'd22, 16'd24};
    run_frame(2, 100, 100, "overlap5x5");
  endtask

  task automatic test_relu();
    stim_q = '{16'hFFFB, 16'd1, 16'hFFFB, 16'd2, 16'hFFFB, 16'd3, 16'hFFFB, 16'd4};
    exp_q = '{16'h0000, 16'h0004};
    run_frame(3, 100, 100, "relu_on");
    exp_q = '{16'hFFFB, 16'h0004};
    run_frame(4, 100, 100, "relu_off");
  endtask

  task automatic test_random_stall();
    int m;
    int v;
    stim_q.delete();
    exp_q.delete();
    for (int i = 0; i < 9 * 10 * 3; i++) stim_q.push_back(DW'($urandom_range(0, 65535)));
    for (int oy = 0; oy < 4; oy++)
      for (int ox = 0; ox < 4; ox++)
        for (int ch = 0; ch < 3; ch++) begin
          m = -100000;
          for (int ky = 0; ky < 3; ky++)
            for (int kx = 0; kx < 3; kx++) begin
              v = $signed(stim_q[((oy * 2 + ky) * 9 + ox * 2 + kx) * 3 + ch]);
              if (v > m) m = v;
            end
          exp_q.push_back(DW'(m));
        end
    run_frame(5, 60, 50, "random");
  endtask

  task automatic test_reset_mid_frame();
    load_ramp(10, 1000);
    dout_rdy[0] = 1'b0;
    send_frame(0, 100);
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if (din_rdy[0] !== 1'b0 || dout_en[0] !== 1'b0 || dout[0] !== '0) begin
      n_errors++;
      $display("[TB] FAIL midreset_state: got rdy=%b en=%b dout=%h, required 0 0 0000",
               din_rdy[0], dout_en[0], dout[0]);
    end
    @(negedge clk);
    rst = 1'b1;
    load_ramp(16, 0);
    exp_q = '{16'd5, 16'd7, 16'd13, 16'd15};
    run_frame(0, 100, 100, "midreset");
  endtask

  initial begin
    rst = 1'b0;
    for (int i = 0; i < N; i++) begin
      din[i]      = '0;
      din_en[i]   = 1'b0;
      din_eop[i]  = 1'b0;
      dout_rdy[i] = 1'b0;
    end
    $display("[TB] start");
    test_reset();
    test_max_basic();
    test_back_to_back();
    test_avg();
    test_overlap();
    test_relu();
    test_random_stall();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
